serie_lane_scheduler: RTL

SERIE_LANE_SCHEDULER -- requirements
Module: serie_lane_scheduler

---
 rtl/serie_lane_scheduler_if.sv | 26 ++
 rtl/serie_lane_scheduler.sv | 102 ++++++++++
 2 files changed

// File: rtl/serie_lane_scheduler_if.sv
// Lane-side and serial-side signals of the two-lane byte serialiser.
// Handshake: a lane byte moves when validN_in & readyN_out are both high in the same cycle;
// validN_in may be held indefinitely, and readyN_out never depends on readiness elsewhere.
interface serie_lane_scheduler_if;
  logic [7:0] data0_in;
  logic       valid0_in;
  logic       ready0_out;
  logic [7:0] data1_in;
  logic       valid1_in;
  logic       ready1_out;
  logic       data_out;
  logic       byte_start;
  logic       lane_sel;
  logic       idle_out;
  logic       active;

  modport master (
    output data0_in, valid0_in, data1_in, valid1_in,
    input  ready0_out, ready1_out, data_out, byte_start, lane_sel, idle_out, active
  );

  modport slave (
    input  data0_in, valid0_in, data1_in, valid1_in,
    output ready0_out, ready1_out, data_out, byte_start, lane_sel, idle_out, active
  );
endinterface

// File: rtl/serie_lane_scheduler.sv
// Serialises bytes from two lanes MSB-first, one bit per clk_8f cycle, with round-robin
// arbitration at each byte boundary and a burst of idle bytes after reset.
module serie_lane_scheduler #(
  parameter logic [7:0]  IDLE_BYTE  = 8'hBC,
  parameter int unsigned SYNC_BYTES = 4
) (
  input  logic                   clk_8f,
  input  logic                   reset,
  serie_lane_scheduler_if.slave  bus,
  output logic                   state_o
);
  typedef enum logic {ST_SYNC = 1'b0, ST_ACTIVE = 1'b1} state_e;

  localparam logic [3:0] SYNC_LAST = 4'(SYNC_BYTES - 1);

  state_e     state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] sync_cnt_q, sync_cnt_d;
  logic       last_grant_q, last_grant_d;
  logic       lane_sel_q, lane_sel_d;
  logic       idle_q, idle_d;
  logic       load_slot, active, grant_valid, grant_lane;

  always_ff @(posedge clk_8f) begin
    if (reset) begin
      state_q      <= ST_SYNC;
      shift_q      <= IDLE_BYTE;
      bit_cnt_q    <= 3'd7;
      sync_cnt_q   <= 4'd0;
      last_grant_q <= 1'b1;
      lane_sel_q   <= 1'b0;
      idle_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      sync_cnt_q   <= sync_cnt_d;
      last_grant_q <= last_grant_d;
      lane_sel_q   <= lane_sel_d;
      idle_q       <= idle_d;
    end
  end

  always_comb begin
    load_slot = (bit_cnt_q == 3'd0);
    // The final sync slot already belongs to the active window so the first lane byte
    // follows the last idle byte without a gap.
    active = !reset && ((state_q == ST_ACTIVE) || (load_slot && sync_cnt_q == SYNC_LAST));

    grant_valid = 1'b0;
    grant_lane  = 1'b0;
    if (active && load_slot) begin
      if (bus.valid0_in && bus.valid1_in) begin
        grant_valid = 1'b1;
        grant_lane  = !last_grant_q;
      end else if (bus.valid0_in) begin
        grant_valid = 1'b1;
        grant_lane  = 1'b0;
      end else if (bus.valid1_in) begin
        grant_valid = 1'b1;
        grant_lane  = 1'b1;
      end
    end

    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q - 3'd1;
    sync_cnt_d   = sync_cnt_q;
    last_grant_d = last_grant_q;
    lane_sel_d   = lane_sel_q;
    idle_d       = idle_q;

    if (load_slot) begin
      if (grant_valid) begin
        shift_d      = grant_lane ? bus.data1_in : bus.data0_in;
        lane_sel_d   = grant_lane;
        idle_d       = 1'b0;
        last_grant_d = grant_lane;
      end else begin
        shift_d    = IDLE_BYTE;
        lane_sel_d = 1'b0;
        idle_d     = 1'b1;
      end
      if (state_q == ST_SYNC) begin
        sync_cnt_d = sync_cnt_q + 4'd1;
        if (sync_cnt_q == SYNC_LAST) state_d = ST_ACTIVE;
      end
    end
  end

  always_comb begin
    bus.data_out   = reset ? IDLE_BYTE[7] : shift_q[bit_cnt_q];
    bus.byte_start = reset || (bit_cnt_q == 3'd7);
    bus.lane_sel   = lane_sel_q;
    bus.idle_out   = idle_q;
    bus.active     = active;
    bus.ready0_out = grant_valid && !grant_lane;
    bus.ready1_out = grant_valid && grant_lane;
    state_o        = (state_q == ST_ACTIVE);
  end
endmodule
